// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_if
//  Purpose  : Parallel result bus of the UART receiver. The receiver drives it
//             through the master modport; the consumer (register file or FIFO)
//             reads it through the slave modport.
//  Signals  : P_DATA      last good received payload
//             data_valid  1-clk strobe, P_DATA updated with a good frame
//             par_err     1-clk strobe, parity mismatch, frame dropped
//             stp_err     1-clk strobe, stop bit sampled low, frame dropped
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output P_DATA,
        output data_valid,
        output par_err,
        output stp_err
    );

    modport slave (
        input  P_DATA,
        input  data_valid,
        input  par_err,
        input  stp_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : UART receiver. Oversamples RX_IN at P clocks per bit (P = 8, 16
//             or 32, anything else treated as 8) and recovers frames made of
//             start bit, DATA_WIDTH data bits LSB first, optional parity bit
//             and one stop bit. Each frame ends in exactly one 1-clk strobe:
//             data_valid, par_err or stp_err.
//  Ports    : clk       single clock
//             rst_n     asynchronous active-low reset
//             RX_IN     serial line, idle high, asynchronous to clk
//             PAR_EN    1 = frame carries a parity bit
//             PAR_TYP   0 = even parity, 1 = odd parity
//             Prescale  clocks per bit (8/16/32)
//             rx_bus    result bus (P_DATA, data_valid, par_err, stp_err)
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               RX_IN,
    input  wire logic               PAR_EN,
    input  wire logic               PAR_TYP,
    input  wire logic [PRESC_W-1:0] Prescale,
    uart_rx_if.master               rx_bus
);

    // Bit-period counter must hold values up to 31.
    localparam int CNT_W = 6;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] C_P8  = CNT_W'(8);
    localparam logic [CNT_W-1:0] C_P16 = CNT_W'(16);
    localparam logic [CNT_W-1:0] C_P32 = CNT_W'(32);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q,      state_d;
    logic                   sync1_q,      sync1_d;
    logic                   rx_s_q,       rx_s_d;
    logic                   rx_prev_q,    rx_prev_d;
    logic [CNT_W-1:0]       edge_cnt_q,   edge_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q,    bit_cnt_d;
    logic [2:0]             smp_q,        smp_d;
    logic [DATA_WIDTH-1:0]  shift_q,      shift_d;
    logic                   par_en_q,     par_en_d;
    logic                   par_typ_q,    par_typ_d;
    logic [CNT_W-1:0]       presc_q,      presc_d;
    logic                   par_bad_q,    par_bad_d;
    logic [DATA_WIDTH-1:0]  p_data_q,     p_data_d;
    logic                   data_valid_q, data_valid_d;
    logic                   par_err_q,    par_err_d;
    logic                   stp_err_q,    stp_err_d;

    // ------------------------------------------------------------------
    // Derived timing points within one bit period
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] last_cnt;
    logic             at_smp0;
    logic             at_smp1;
    logic             at_smp2;
    logic             at_decide;
    logic             at_last;
    logic             majority;
    logic             fall;
    logic [CNT_W-1:0] presc_sel;

    assign half      = presc_q >> 1;
    assign last_cnt  = presc_q - CNT_W'(1);
    assign at_smp0   = (edge_cnt_q == (half - CNT_W'(1)));
    assign at_smp1   = (edge_cnt_q == half);
    assign at_smp2   = (edge_cnt_q == (half + CNT_W'(1)));
    // The third sample is registered at half+1, so all three are stable here.
    assign at_decide = (edge_cnt_q == (half + CNT_W'(2)));
    assign at_last   = (edge_cnt_q == last_cnt);
    assign majority  = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    // Edge rather than level, so a held-low line (break) cannot restart frames.
    assign fall      = rx_prev_q & ~rx_s_q;

    always_comb begin
        presc_sel = C_P8;
        if (Prescale == PRESC_W'(16)) begin
            presc_sel = C_P16;
        end else if (Prescale == PRESC_W'(32)) begin
            presc_sel = C_P32;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        sync1_d      = RX_IN;
        rx_s_d       = sync1_q;
        rx_prev_d    = rx_s_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        smp_d        = smp_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        presc_d      = presc_q;
        par_bad_d    = par_bad_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        // Oversampling and bit-period counting run in every active state.
        if (state_q != S_IDLE) begin
            if (at_smp0) smp_d[0] = rx_s_q;
            if (at_smp1) smp_d[1] = rx_s_q;
            if (at_smp2) smp_d[2] = rx_s_q;
            edge_cnt_d = at_last ? '0 : edge_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (fall) begin
                    state_d   = S_START;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    presc_d   = presc_sel;
                    par_bad_d = 1'b0;
                end
            end

            S_START: begin
                if (at_decide && majority) begin
                    // Start bit did not hold low to its centre: noise.
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                end else if (at_last) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end

            S_DATA: begin
                if (at_decide) begin
                    shift_d = {majority, shift_q[DATA_WIDTH-1:1]};
                end
                if (at_last) begin
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end

            S_PARITY: begin
                if (at_decide) begin
                    par_bad_d = (majority != ((^shift_q) ^ par_typ_q));
                end
                if (at_last) begin
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                // Leaving at mid stop bit gives half a bit of skew margin and
                // lets the next start edge follow with no idle gap.
                if (at_decide) begin
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                    if (!majority) begin
                        stp_err_d = 1'b1;
                    end else if (par_bad_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d    = S_IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            smp_q        <= 3'b111;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            presc_q      <= C_P8;
            par_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rx_s_q       <= rx_s_d;
            rx_prev_q    <= rx_prev_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            smp_q        <= smp_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            presc_q      <= presc_d;
            par_bad_q    <= par_bad_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign rx_bus.P_DATA     = p_data_q;
    assign rx_bus.data_valid = data_valid_q;
    assign rx_bus.par_err    = par_err_q;
    assign rx_bus.stp_err    = stp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. Frames are serialised at the
//             negative clock edge; a frame-level model predicts each frame's
//             single outcome (kind, P_DATA, strobe cycle) and a monitor compares
//             every observed strobe against it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int DW = 8;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       RX_IN    = 1'b1;
    logic       PAR_EN   = 1'b0;
    logic       PAR_TYP  = 1'b0;
    logic [5:0] Prescale = 6'd8;

    uart_rx_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx #(.DATA_WIDTH(DW), .PRESC_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RX_IN    (RX_IN),
        .PAR_EN   (PAR_EN),
        .PAR_TYP  (PAR_TYP),
        .Prescale (Prescale),
        .rx_bus   (bus)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // kind: 3'b001 data_valid, 3'b010 par_err, 3'b100 stp_err
    typedef struct {
        logic [2:0]  kind;
        logic [7:0]  data;
        int unsigned cyc;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        logic       par_flip;
        logic       stop_val;
        logic       spike;
        logic [5:0] presc;
    } frame_t;

    ev_t        exp_q[$];
    logic [7:0] exp_pdata = 8'h00;

    function automatic int eff_p(input logic [5:0] pr);
        if (pr == 6'd16) return 16;
        if (pr == 6'd32) return 32;
        return 8;
    endfunction

    function automatic frame_t mk(input logic [7:0] d, input logic pe, input logic pt,
                                  input logic flip, input logic stp, input logic spk,
                                  input logic [5:0] pr);
        frame_t f;
        f.data = d; f.par_en = pe; f.par_typ = pt; f.par_flip = flip;
        f.stop_val = stp; f.spike = spk; f.presc = pr;
        return f;
    endfunction

    // Serialise one frame; predict its outcome when the start bit goes out.
    task automatic send_frame(input frame_t f);
        int   p;
        int   nb;
        logic bits [0:10];
        ev_t  e;
        p = eff_p(f.presc);
        bits[0] = 1'b0;
        for (int j = 0; j < DW; j++) bits[1+j] = f.data[j];
        nb = 1 + DW;
        if (f.par_en) begin
            bits[nb] = (^f.data) ^ f.par_typ ^ f.par_flip;
            nb++;
        end
        bits[nb] = f.stop_val;
        nb++;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < p; i++) begin
                @(negedge clk);
                if (b == 0 && i == 0) begin
                    PAR_EN   = f.par_en;
                    PAR_TYP  = f.par_typ;
                    Prescale = f.presc;
                    // Strobe: 2 sync + (1+DW+PAR_EN)*P + P/2 + 3 clocks after
                    // the edge that first samples the falling RX_IN (cyc+1).
                    e.cyc = (cyc + 1) + 2 + (1 + DW + (f.par_en ? 1 : 0)) * p + p / 2 + 3;
                    if (!f.stop_val) begin
                        e.kind = 3'b100;
                    end else if (f.par_en && f.par_flip) begin
                        e.kind = 3'b010;
                    end else begin
                        e.kind    = 3'b001;
                        exp_pdata = f.data;
                    end
                    e.data = exp_pdata;
                    exp_q.push_back(e);
                end
                if (b == 3 && i == 1) begin
                    // Configuration changes mid-frame must be ignored.
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                    Prescale = 6'($urandom);
                end
                RX_IN = (f.spike && i == p / 2) ? ~bits[b] : bits[b];
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            RX_IN = 1'b1;
        end
    endtask

    task automatic drain(input string tag);
        idle(40);
        chk({tag, "_missing_strobe"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every strobe must match the next predicted frame outcome.
    ev_t        mon_e;
    logic [2:0] mon_kind;
    always @(negedge clk) begin
        if (rst_n) begin
            mon_kind = {bus.stp_err, bus.par_err, bus.data_valid};
            if (mon_kind != 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {29'd0, mon_kind}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("strobe_kind", {29'd0, mon_kind}, {29'd0, mon_e.kind});
                    chk("strobe_p_data", {24'd0, bus.P_DATA}, {24'd0, mon_e.data});
                    chk("strobe_latency", cyc, mon_e.cyc);
                end
            end
        end
    end

    logic [7:0] part;
    logic [5:0] ptab [0:9];

    initial begin
        ptab = '{6'd8, 6'd16, 6'd32, 6'd8, 6'd16, 6'd32, 6'd0, 6'd5, 6'd12, 6'd63};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_p_data", {24'd0, bus.P_DATA}, 32'd0);
        chk("reset_data_valid", {31'd0, bus.data_valid}, 32'd0);
        chk("reset_par_err", {31'd0, bus.par_err}, 32'd0);
        chk("reset_stp_err", {31'd0, bus.stp_err}, 32'd0);
        rst_n = 1'b1;
        idle(5);

        // Good frame with even parity
        send_frame(mk(8'hA5, 1, 0, 0, 1, 0, 6'd8));
        drain("good_a5");
        chk("hold_after_good", {24'd0, bus.P_DATA}, 32'hA5);

        // Wrong parity bit
        send_frame(mk(8'hA5, 1, 0, 1, 1, 0, 6'd8));
        drain("parity_err");
        chk("hold_after_par_err", {24'd0, bus.P_DATA}, 32'hA5);

        // Stop bit low, no parity
        send_frame(mk(8'h3C, 0, 0, 0, 0, 0, 6'd16));
        drain("stop_err");
        chk("hold_after_stp_err", {24'd0, bus.P_DATA}, 32'hA5);

        // Short low glitch on an idle line, then a real frame
        @(negedge clk);
        Prescale = 6'd16;
        PAR_EN   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            RX_IN = 1'b0;
        end
        drain("glitch");
        send_frame(mk(8'h55, 0, 0, 0, 1, 0, 6'd16));
        drain("after_glitch");
        chk("p_data_55", {24'd0, bus.P_DATA}, 32'h55);

        // Back-to-back frames, odd parity, zero gap
        send_frame(mk(8'h00, 1, 1, 0, 1, 0, 6'd32));
        send_frame(mk(8'hFF, 1, 1, 0, 1, 0, 6'd32));
        drain("back_to_back");
        chk("p_data_ff", {24'd0, bus.P_DATA}, 32'hFF);

        // Single-clock inverted spike at every bit centre
        send_frame(mk(8'h6B, 1, 0, 0, 1, 1, 6'd8));
        send_frame(mk(8'h92, 0, 0, 0, 1, 1, 6'd16));
        send_frame(mk(8'hC7, 1, 1, 0, 1, 1, 6'd32));
        drain("spikes");

        // Break: line held low well beyond a frame -> one stp_err only
        send_frame(mk(8'h00, 0, 0, 0, 0, 0, 6'd8));
        repeat (300) begin
            @(negedge clk);
            RX_IN = 1'b0;
        end
        drain("break");
        send_frame(mk(8'h5A, 0, 0, 0, 1, 0, 6'd8));
        drain("after_break");
        chk("p_data_5a", {24'd0, bus.P_DATA}, 32'h5A);

        // Reset in the middle of data bit 4
        part = 8'h3C;
        @(negedge clk);
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                RX_IN = (b == 0) ? 1'b0 : part[b-1];
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            RX_IN = part[4];
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_p_data", {24'd0, bus.P_DATA}, 32'd0);
        chk("midreset_data_valid", {31'd0, bus.data_valid}, 32'd0);
        chk("midreset_par_err", {31'd0, bus.par_err}, 32'd0);
        chk("midreset_stp_err", {31'd0, bus.stp_err}, 32'd0);
        RX_IN = 1'b1;
        exp_q.delete();
        exp_pdata = 8'h00;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        send_frame(mk(8'h81, 0, 0, 0, 1, 0, 6'd8));
        drain("after_reset");
        chk("p_data_81", {24'd0, bus.P_DATA}, 32'h81);

        // Randomised frames with random gaps (often zero)
        for (int n = 0; n < 40; n++) begin
            frame_t f;
            int     gap;
            int     p;
            f = mk(8'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) != 0),
                   ($urandom_range(0, 2) == 0), ptab[$urandom_range(0, 9)]);
            send_frame(f);
            p = eff_p(f.presc);
            if (!f.stop_val) gap = $urandom_range(2, 5);
            else if ($urandom_range(0, 2) == 0) gap = 0;
            else gap = $urandom_range(1, p);
            idle(gap);
        end
        drain("random");
        chk("p_data_final", {24'd0, bus.P_DATA}, {24'd0, exp_pdata});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
